// File: rtl/fsm_seq_detect_param_if.sv
// Bundles the configuration, serial input and status signals of the pattern detector.
// The master side drives config and data; the slave side is the detector.
interface fsm_seq_detect_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned SW = $clog2(PAT_W + 1);

    logic             cfg_en;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_overlap;
    logic             in_val;
    logic             in_;
    logic             match;
    logic [SW-1:0]    state;
    logic [CNT_W-1:0] count;

    modport master (
        output cfg_en, cfg_pattern, cfg_overlap, in_val, in_,
        input  match, state, count
    );

    modport slave (
        input  cfg_en, cfg_pattern, cfg_overlap, in_val, in_,
        output match, state, count
    );
endinterface

// File: rtl/fsm_seq_detect_param.sv
// Moore detector for a programmable PAT_W-bit serial pattern with overlap/non-overlap
// modes, a valid qualifier and a saturating match counter. All outputs are registered.
module fsm_seq_detect_param #(
    parameter int unsigned      PAT_W     = 4,
    parameter int unsigned      CNT_W     = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = 4'b1011
) (
    input logic                 clk,
    input logic                 reset,
    fsm_seq_detect_param_if.slave bus
);
    localparam int unsigned      SW     = $clog2(PAT_W + 1);
    localparam logic [SW-1:0]    Full   = SW'(PAT_W);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [PAT_W-1:0] pat_q;
    logic             ovl_q;
    logic [SW-1:0]    state_q, state_d;
    logic             match_q;
    logic [CNT_W-1:0] count_q;
    logic [SW-1:0]    from_s;

    // Longest prefix of pat that is a suffix of (prefix(s) followed by b). Since s is the
    // longest matched prefix, that string holds all history relevant to the fallback.
    function automatic logic [SW-1:0] next_state(input logic [SW-1:0] s, input logic b,
                                                 input logic [PAT_W-1:0] pat);
        logic [PAT_W:0] x;
        logic [SW-1:0]  res;
        logic           ok;
        int             idx;
        x = {pat, 1'b0};
        x[int'(PAT_W) - int'(s)] = b;
        res = '0;
        for (int k = 1; k <= int'(PAT_W); k++) begin
            if (k <= int'(s) + 1) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    idx = int'(s) + 1 - k + j;
                    if (x[int'(PAT_W) - idx] != pat[int'(PAT_W) - 1 - j]) ok = 1'b0;
                end
                if (ok) res = SW'(k);
            end
        end
        return res;
    endfunction

    always_comb begin
        from_s  = (state_q == Full && !ovl_q) ? '0 : state_q;
        state_d = next_state(from_s, bus.in_, pat_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= RESET_PAT;
            ovl_q   <= 1'b1;
            state_q <= '0;
            match_q <= 1'b0;
            count_q <= '0;
        end else if (bus.cfg_en) begin
            pat_q   <= bus.cfg_pattern;
            ovl_q   <= bus.cfg_overlap;
            state_q <= '0;
            match_q <= 1'b0;
            count_q <= '0;
        end else if (bus.in_val) begin
            state_q <= state_d;
            match_q <= (state_d == Full);
            if (state_d == Full && count_q != CntMax) count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.state = state_q;
    assign bus.match = match_q;
    assign bus.count = count_q;
endmodule
